// File: rtl/xbar_rr_arbiter.sv
// xbar_rr_arbiter
//   Round-robin arbiter that configures one crossbar output. A winner is
//   picked in IDLE, its index is offered as a control word in CONFIG, and
//   the input holds the output in GRANT for up to BURST_LEN transfers or
//   until it drops its request. The releasing input becomes lowest priority.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   req_val      per-input request (tap of crossbar recv_val)
//   xfer_val     crossbar output send_val
//   xfer_rdy     crossbar output send_rdy
//   control      crossbar config word, granted index in the top SEL_W bits
//   control_val  control word valid (CONFIG only)
//   control_rdy  crossbar accepts control word
//   grant_oh     one-hot grant, all-zero outside GRANT
//   busy         high in CONFIG and GRANT
module xbar_rr_arbiter #(
    parameter int N_INPUTS          = 4,
    parameter int CONTROL_BIT_WIDTH = 32,
    parameter int BURST_LEN         = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_INPUTS-1:0]          req_val,
    input  logic                         xfer_val,
    input  logic                         xfer_rdy,
    output logic [CONTROL_BIT_WIDTH-1:0] control,
    output logic                         control_val,
    input  logic                         control_rdy,
    output logic [N_INPUTS-1:0]          grant_oh,
    output logic                         busy
);

    localparam int SEL_W = $clog2(N_INPUTS);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, CONFIG, GRANT} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;     // latched grant index
    logic [SEL_W-1:0]   ptr_q, ptr_d;     // highest-priority index
    logic [CNT_W-1:0]   beat_q, beat_d;   // completed transfers this grant

    logic [SEL_W-1:0]   winner;
    logic               any_req;
    logic               fire;
    logic               rel;
    int                 idx;

    // Rotating priority search. Walking offsets from high to low lets the
    // smallest offset from ptr overwrite any earlier hit, so it wins.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int i = N_INPUTS - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_INPUTS) idx = idx - N_INPUTS;
            if (req_val[SEL_W'(idx)]) begin
                winner  = SEL_W'(idx);
                any_req = 1'b1;
            end
        end
    end

    assign fire = xfer_val & xfer_rdy;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        rel     = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    sel_d   = winner;
                    state_d = CONFIG;
                end
            end
            CONFIG: begin
                if (control_rdy) begin
                    beat_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // A completed beat always counts; a dropped request only
                // releases on a cycle with no transfer.
                if (fire) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == CNT_W'(BURST_LEN - 1)) rel = 1'b1;
                end else if (!req_val[sel_q]) begin
                    rel = 1'b1;
                end
                if (rel) begin
                    state_d = IDLE;
                    ptr_d   = (sel_q == SEL_W'(N_INPUTS - 1)) ? '0 : sel_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
        end
    end

    // Outputs decode straight from registered state so reset clears them
    // without waiting for an edge.
    assign busy        = (state_q != IDLE);
    assign control_val = (state_q == CONFIG);
    assign grant_oh    = (state_q == GRANT) ? (N_INPUTS'(1) << sel_q) : '0;
    assign control     = busy ? {sel_q, {(CONTROL_BIT_WIDTH - SEL_W){1'b0}}} : '0;

endmodule

// File: tb/tb_xbar_rr_arbiter.sv
module tb_xbar_rr_arbiter;

    logic        clk;
    logic        rst;

    logic [3:0]  r4;
    logic        xv4, xr4, cr4;
    logic [31:0] ctrl4;
    logic        cval4, busy4;
    logic [3:0]  goh4;

    logic [2:0]  r3;
    logic        xv3, xr3, cr3;
    logic [7:0]  ctrl3;
    logic        cval3, busy3;
    logic [2:0]  goh3;

    int checks   = 0;
    int failures = 0;

    xbar_rr_arbiter #(.N_INPUTS(4), .CONTROL_BIT_WIDTH(32), .BURST_LEN(4)) u_dut4 (
        .clk(clk), .reset(rst), .req_val(r4), .xfer_val(xv4), .xfer_rdy(xr4),
        .control(ctrl4), .control_val(cval4), .control_rdy(cr4),
        .grant_oh(goh4), .busy(busy4)
    );

    xbar_rr_arbiter #(.N_INPUTS(3), .CONTROL_BIT_WIDTH(8), .BURST_LEN(2)) u_dut3 (
        .clk(clk), .reset(rst), .req_val(r3), .xfer_val(xv3), .xfer_rdy(xr3),
        .control(ctrl3), .control_val(cval3), .control_rdy(cr3),
        .grant_oh(goh3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control word is only compared while it is being offered.
    task automatic st4(input string tag, input logic e_cval, input logic [31:0] e_ctrl,
                       input logic [3:0] e_goh, input logic e_busy);
        chk({tag, "_cval"}, {31'd0, cval4}, {31'd0, e_cval});
        if (e_cval) chk({tag, "_ctrl"}, ctrl4, e_ctrl);
        chk({tag, "_goh"}, {28'd0, goh4}, {28'd0, e_goh});
        chk({tag, "_busy"}, {31'd0, busy4}, {31'd0, e_busy});
    endtask

    task automatic st3(input string tag, input logic e_cval, input logic [7:0] e_ctrl,
                       input logic [2:0] e_goh, input logic e_busy);
        chk({tag, "_cval"}, {31'd0, cval3}, {31'd0, e_cval});
        if (e_cval) chk({tag, "_ctrl"}, {24'd0, ctrl3}, {24'd0, e_ctrl});
        chk({tag, "_goh"}, {29'd0, goh3}, {29'd0, e_goh});
        chk({tag, "_busy"}, {31'd0, busy3}, {31'd0, e_busy});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r4 = '0; xv4 = 0; xr4 = 0; cr4 = 0;
        r3 = '0; xv3 = 0; xr3 = 0; cr3 = 0;
        tick();
        rst = 1'b0;
    endtask

    int          exp_b [5] = '{0, 1, 2, 3, 0};
    logic [3:0]  oh;
    logic [31:0] cw;

    initial begin
        rst = 1'b1;
        r4 = '0; xv4 = 0; xr4 = 0; cr4 = 0;
        r3 = '0; xv3 = 0; xr3 = 0; cr3 = 0;
        #3;
        st4("rst4", 0, 32'h0, 4'b0000, 0);
        chk("rst4_ctrl", ctrl4, 32'h0);
        st3("rst3", 0, 8'h0, 3'b000, 0);
        tick(); tick();
        rst = 1'b0;

        // Single request to input 2, full burst, pointer lands on 3
        r4 = 4'b0100; cr4 = 1;
        tick(); st4("A_cfg", 1, 32'h8000_0000, 4'b0000, 1);
        xv4 = 1; xr4 = 1;
        tick(); st4("A_grant", 0, 32'h0, 4'b0100, 1);
        repeat (3) begin tick(); st4("A_beat", 0, 32'h0, 4'b0100, 1); end
        tick(); st4("A_idle", 0, 32'h0, 4'b0000, 0);
        r4 = 4'b1100; xv4 = 0; xr4 = 0;
        tick(); st4("A_ptr3", 1, 32'hC000_0000, 4'b0000, 1);
        do_reset();

        // All requesting, continuous transfers: strict rotation
        r4 = 4'b1111; cr4 = 1; xv4 = 1; xr4 = 1;
        for (int g = 0; g < 5; g++) begin
            oh = 4'b0001 << exp_b[g];
            cw = 32'(exp_b[g]) << 30;
            tick(); st4("B_cfg", 1, cw, 4'b0000, 1);
            tick(); st4("B_grant", 0, 32'h0, oh, 1);
            repeat (3) begin tick(); st4("B_beat", 0, 32'h0, oh, 1); end
            tick(); st4("B_idle", 0, 32'h0, 4'b0000, 0);
        end
        do_reset();

        // Early release after two beats when the request drops
        r4 = 4'b0010; cr4 = 1; xv4 = 1; xr4 = 1;
        tick(); st4("C_cfg", 1, 32'h4000_0000, 4'b0000, 1);
        tick(); st4("C_grant", 0, 32'h0, 4'b0010, 1);
        tick(); st4("C_b1", 0, 32'h0, 4'b0010, 1);
        tick(); st4("C_b2", 0, 32'h0, 4'b0010, 1);
        r4 = 4'b0000; xv4 = 0;
        tick(); st4("C_idle", 0, 32'h0, 4'b0000, 0);
        r4 = 4'b0110;
        tick(); st4("C_ptr2", 1, 32'h8000_0000, 4'b0000, 1);
        do_reset();

        // control_rdy held low in CONFIG; request churn and xfers ignored there
        r4 = 4'b1000; cr4 = 0; xv4 = 1; xr4 = 1;
        tick(); st4("D_cfg1", 1, 32'hC000_0000, 4'b0000, 1);
        r4 = 4'b0001;
        tick(); st4("D_cfg2", 1, 32'hC000_0000, 4'b0000, 1);
        tick(); st4("D_cfg3", 1, 32'hC000_0000, 4'b0000, 1);
        cr4 = 1;
        tick(); st4("D_grant", 0, 32'h0, 4'b1000, 1);
        // request already low, but a beat completes: grant must hold
        tick(); st4("D_beat_hold", 0, 32'h0, 4'b1000, 1);
        xv4 = 0;
        tick(); st4("D_idle", 0, 32'h0, 4'b0000, 0);
        r4 = 4'b1001;
        tick(); st4("D_ptr0", 1, 32'h0000_0000, 4'b0000, 1);
        do_reset();

        // Reset mid-grant: outputs clear at once, pointer back to 0
        r4 = 4'b0010; cr4 = 1;
        tick(); st4("E_cfg1", 1, 32'h4000_0000, 4'b0000, 1);
        tick(); st4("E_grant1", 0, 32'h0, 4'b0010, 1);
        r4 = 4'b0000;
        tick(); st4("E_idle1", 0, 32'h0, 4'b0000, 0);
        r4 = 4'b0100;
        tick(); st4("E_cfg2", 1, 32'h8000_0000, 4'b0000, 1);
        tick(); st4("E_grant2", 0, 32'h0, 4'b0100, 1);
        xv4 = 1; xr4 = 1;
        tick(); st4("E_beat", 0, 32'h0, 4'b0100, 1);
        #3 rst = 1'b1;
        #1;
        st4("E_async", 0, 32'h0, 4'b0000, 0);
        chk("E_async_ctrl", ctrl4, 32'h0);
        tick();
        rst = 1'b0; xv4 = 0; xr4 = 0; r4 = 4'b1010;
        tick(); st4("E_after_rst", 1, 32'h4000_0000, 4'b0000, 1);
        do_reset();
        r4 = 4'b1000; cr4 = 1;
        tick(); st4("E_req3", 1, 32'hC000_0000, 4'b0000, 1);
        do_reset();

        // N=3: pointer wraps from 2 back to 0
        r3 = 3'b100; cr3 = 1;
        tick(); st3("F_cfg", 1, 8'h80, 3'b000, 1);
        xv3 = 1; xr3 = 1;
        tick(); st3("F_grant", 0, 8'h0, 3'b100, 1);
        tick(); st3("F_b1", 0, 8'h0, 3'b100, 1);
        tick(); st3("F_idle", 0, 8'h0, 3'b000, 0);
        r3 = 3'b011; xv3 = 0; xr3 = 0;
        tick(); st3("F_wrap_cfg", 1, 8'h00, 3'b000, 1);
        tick(); st3("F_wrap_grant", 0, 8'h0, 3'b001, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xbar_rr_arbiter.md
XBAR_RR_ARBITER -- requirements
Module: xbar_rr_arbiter

Interface
REQ-001 Parameter N_INPUTS, default 4, number of crossbar inputs to arbitrate; legal range 2..16, need not be a power of two.
REQ-002 Parameter CONTROL_BIT_WIDTH, default 32, width of the crossbar control word.
REQ-003 Parameter BURST_LEN, default 4, maximum transfers per grant; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_val  input  N_INPUTS  per-input request; tap of the crossbar recv_val bits.
REQ-007 xfer_val  input  1  crossbar output send_val.
REQ-008 xfer_rdy  input  1  crossbar output send_rdy.
REQ-009 control  output  CONTROL_BIT_WIDTH  crossbar configuration word.
REQ-010 control_val  output  1  control word valid.
REQ-011 control_rdy  input  1  crossbar accepts control word.
REQ-012 grant_oh  output  N_INPUTS  one-hot current grant; all-zero when no grant is active.
REQ-013 busy  output  1  high in CONFIG and GRANT states.

Function
REQ-014 The FSM SHALL have three states: IDLE, CONFIG and GRANT.
REQ-015 Selection: SEL_W = $clog2(N_INPUTS); control[CONTROL_BIT_WIDTH-1 -: SEL_W] = granted index; all other control bits 0.
REQ-016 IDLE, any req_val bit high: winner = first set bit searching upward from priority pointer ptr, wrapping N_INPUTS-1 -> 0; winner latched; next state CONFIG.
REQ-017 IDLE, req_val all zero: remain in IDLE; control_val = 0; grant_oh = 0.
REQ-018 CONFIG: control_val = 1 and control holds the latched index; control SHALL stay stable until control_rdy is high.
REQ-019 CONFIG with control_rdy = 1: next state GRANT, beat counter cleared to 0; with control_rdy = 0: remain in CONFIG.
REQ-020 Latency: request seen in IDLE at cycle t -> control_val high at t+1 -> GRANT at t+2 when control_rdy is high at t+1.
REQ-021 GRANT: grant_oh has the granted bit set; control_val = 0; each cycle with xfer_val & xfer_rdy increments the beat counter.
REQ-022 GRANT releases on the cycle the BURST_LEN-th transfer completes -> next state IDLE.
REQ-023 GRANT releases early when req_val[grant] = 0 and no transfer completes that cycle -> next state IDLE.
REQ-024 A transfer and a deasserted req_val in the same cycle SHALL count the beat; release then follows REQ-022/REQ-023 on later cycles.
REQ-025 On every release: ptr <= granted index + 1, wrapping to 0 after N_INPUTS-1, so the releasing input gets lowest priority.
REQ-026 At least one IDLE cycle SHALL separate consecutive grants; there is no back-to-back regrant.
REQ-027 Beat counter width = $clog2(BURST_LEN+1); the counter SHALL never exceed BURST_LEN.
REQ-028 Request changes during CONFIG or GRANT SHALL NOT alter the latched grant.
REQ-029 xfer_val/xfer_rdy activity in IDLE or CONFIG SHALL be ignored.

Reset
REQ-030 Asserting reset SHALL immediately, without waiting for a clock edge, force: state = IDLE, ptr = 0, beat counter = 0, latched index = 0, control = 0, control_val = 0, grant_oh = 0, busy = 0.
REQ-031 Reset asserted mid-CONFIG or mid-GRANT SHALL abandon the grant with no pointer update; the first arbitration after reset starts from index 0.

Verification
REQ-032 N=4, BURST_LEN=4, req_val=0b0100 from reset, control_rdy=1 -> control_val at t+1 with control[31:30]=2; grant_oh=0b0100 at t+2; after 4 transfers -> IDLE, ptr=3.
REQ-033 req_val=0b1111 held, continuous transfers -> grants in order 0,1,2,3,0; each grant lasts 4 beats; one IDLE cycle between grants.
REQ-034 Grant to input 1, req_val[1] drops after 2 beats with no transfer that cycle -> release the same cycle, IDLE next cycle, ptr=2.
REQ-035 control_rdy held 0 for 3 cycles in CONFIG -> control_val=1 with stable control for all 3 cycles; GRANT entered the cycle after control_rdy rises.
REQ-036 Reset pulse asserted between clock edges during GRANT -> grant_oh, control_val and busy go to 0 immediately; with req_val=0b1000 after reset, the search starts from ptr=0 and grants input 3.
REQ-037 N=3, grant to input 2 with release -> ptr wraps to 0; req_val=0b011 -> input 0 granted.
